// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: instruction-memory handshake, hazard hold,
// redirect requests and the PC Enable/Control/Target drive.
// The master side is the sequencer; the slave side is the pipeline/memory.
// Macro FETCH_SEQUENCER_TRAP_EN adds the trap_req request line.
interface fetch_sequencer_if;
  logic        imem_ready;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
`ifdef FETCH_SEQUENCER_TRAP_EN
  logic        trap_req;
`endif
  logic        pc_enable;
  logic        pc_control;
  logic [31:0] pc_target;
  logic        imem_req;
  logic        flush_if;
  logic        flush_id;

`ifdef FETCH_SEQUENCER_TRAP_EN
  modport master (
    input  imem_ready, stall, br_taken, br_target, jmp_valid, jmp_target, trap_req,
    output pc_enable, pc_control, pc_target, imem_req, flush_if, flush_id
  );
  modport slave (
    output imem_ready, stall, br_taken, br_target, jmp_valid, jmp_target, trap_req,
    input  pc_enable, pc_control, pc_target, imem_req, flush_if, flush_id
  );
`else
  modport master (
    input  imem_ready, stall, br_taken, br_target, jmp_valid, jmp_target,
    output pc_enable, pc_control, pc_target, imem_req, flush_if, flush_id
  );
  modport slave (
    output imem_ready, stall, br_taken, br_target, jmp_valid, jmp_target,
    input  pc_enable, pc_control, pc_target, imem_req, flush_if, flush_id
  );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC enable/control/target and the instruction
// fetch request. Redirects (trap > branch > jump) act in the same cycle when
// memory is ready, otherwise they are held in a pending register until the
// outstanding fetch completes.
// Optional feature macro: FETCH_SEQUENCER_TRAP_EN (trap_req, target TRAP_VECTOR).
// Outputs are a combinational function of the registered state and the
// current inputs so that redirects and flushes have zero latency.
module fetch_sequencer #(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input logic              Clk,
  input logic              Reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_PEND = 2'd3
  } state_e;

  localparam logic [4:0] BOOT_LOAD = 5'(BOOT_CYCLES);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [1:0]  pend_prio_q, pend_prio_d;

  logic        trap_s;
  logic [1:0]  req_prio_s;
  logic [31:0] req_tgt_s;
  logic        accept_s;
  logic        en_s, ctl_s, req_s, fif_s, fid_s;
  logic [31:0] tgt_s;

`ifdef FETCH_SEQUENCER_TRAP_EN
  assign trap_s = bus.trap_req;
`else
  assign trap_s = 1'b0;
`endif

  // Pick the highest-priority redirect request (3 = trap, 2 = branch, 1 = jump).
  always_comb begin
    req_prio_s = 2'd0;
    req_tgt_s  = 32'h0000_0000;
    if (trap_s) begin
      req_prio_s = 2'd3;
      req_tgt_s  = TRAP_VECTOR;
    end else if (bus.br_taken) begin
      req_prio_s = 2'd2;
      req_tgt_s  = bus.br_target;
    end else if (bus.jmp_valid) begin
      req_prio_s = 2'd1;
      req_tgt_s  = bus.jmp_target;
    end else begin
      req_prio_s = 2'd0;
      req_tgt_s  = 32'h0000_0000;
    end
  end

  // Next-state and output decode for the sequencer FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_tgt_d  = pend_tgt_q;
    pend_prio_d = pend_prio_q;
    accept_s    = 1'b0;
    en_s        = 1'b0;
    ctl_s       = 1'b0;
    tgt_s       = 32'h0000_0000;
    req_s       = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // Redirects are ignored; count down the boot delay.
        if (cnt_q <= 5'd1) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_RUN, ST_WAIT: begin
        req_s    = 1'b1;
        accept_s = (req_prio_s != 2'd0);
        if (accept_s) begin
          if (bus.imem_ready) begin
            en_s    = 1'b1;
            ctl_s   = 1'b1;
            tgt_s   = req_tgt_s;
            state_d = ST_RUN;
          end else begin
            pend_tgt_d  = req_tgt_s;
            pend_prio_d = req_prio_s;
            state_d     = ST_PEND;
          end
        end else if (bus.imem_ready) begin
          en_s    = ~bus.stall;
          state_d = ST_RUN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_PEND: begin
        // An equal or higher-priority redirect replaces the held one.
        req_s    = 1'b1;
        accept_s = (req_prio_s != 2'd0) && (req_prio_s >= pend_prio_q);
        if (bus.imem_ready) begin
          en_s        = 1'b1;
          ctl_s       = 1'b1;
          tgt_s       = accept_s ? req_tgt_s : pend_tgt_q;
          pend_prio_d = 2'd0;
          state_d     = ST_RUN;
        end else if (accept_s) begin
          pend_tgt_d  = req_tgt_s;
          pend_prio_d = req_prio_s;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d = ST_BOOT;
        cnt_d   = BOOT_LOAD;
      end
    endcase
    // Flushes accompany every accepted redirect; branch and trap also kill ID.
    fif_s = accept_s;
    fid_s = accept_s && (req_prio_s >= 2'd2);
  end

  // State, boot counter and pending redirect registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_BOOT;
      cnt_q       <= BOOT_LOAD;
      pend_tgt_q  <= 32'h0000_0000;
      pend_prio_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_prio_q <= pend_prio_d;
    end
  end

  // All outputs are forced low while Reset is high.
  assign bus.pc_enable  = ~Reset & en_s;
  assign bus.pc_control = ~Reset & ctl_s;
  assign bus.pc_target  = (Reset | ~ctl_s) ? 32'h0000_0000 : tgt_s;
  assign bus.imem_req   = ~Reset & req_s;
  assign bus.flush_if   = ~Reset & fif_s;
  assign bus.flush_id   = ~Reset & fid_s;

endmodule
